mem_responder: RTL and testbench

Memory-side responder for the CPU control FSM's ram_cs/ram_we/ram_oe strobe interface. It latches a single-cycle request and serves it from an internal word-addressed array after a configurable number of wait states. It returns read data with a one-cycle ready pulse and flags illegal requests. It sits between the CPU core and the instruction/data store and replaces the zero-latency RAM model.

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 135 +++++++++++++
 tb/tb_mem_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Strobe-style memory bus between the CPU control FSM (master) and mem_responder (slave).
// Fixed 32-bit data path, so wstrb carries one enable per byte lane.
interface mem_responder_if;
   logic        ram_cs;
   logic        ram_we;
   logic        ram_oe;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        ready;
   logic        err;

   modport master (
      output ram_cs, ram_we, ram_oe, addr, wdata, wstrb,
      input  rdata, ready, err
   );

   modport slave (
      input  ram_cs, ram_we, ram_oe, addr, wdata, wstrb,
      output rdata, ready, err
   );
endinterface

// File: rtl/mem_responder.sv
// Wait-stated memory responder: latches one strobe request, answers with a one-cycle ready pulse.
// Optional MEM_BYTE_WRITE_EN honours wstrb on writes; otherwise every legal write is full-word.
module mem_responder #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst,
   mem_responder_if.slave  bus
);

   localparam int         DEPTH    = 2 ** ADDR_W;
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

   state_t            state;
   logic [3:0]        wait_cnt;
   logic              req_we;
   logic              req_oe;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic [3:0]        req_wstrb;
   logic [DATA_W-1:0] mem [DEPTH];

   // In IDLE the live bus is the request (zero-wait path); afterwards the latched copy is.
   logic              cur_we;
   logic              cur_oe;
   logic [31:0]       cur_addr;
   logic [31:0]       cur_wdata;
   logic [3:0]        cur_wstrb;

   assign cur_we    = (state == S_IDLE) ? bus.ram_we : req_we;
   assign cur_oe    = (state == S_IDLE) ? bus.ram_oe : req_oe;
   assign cur_addr  = (state == S_IDLE) ? bus.addr   : req_addr;
   assign cur_wdata = (state == S_IDLE) ? bus.wdata  : req_wdata;
   assign cur_wstrb = (state == S_IDLE) ? bus.wstrb  : req_wstrb;

   logic [ADDR_W-1:0] idx;
   logic              misaligned;
   logic              out_of_range;
   logic              is_read;
   logic              is_write;
   logic              is_illegal;
   logic              resp_err;
   logic              enter_resp;
   logic              do_write;
   logic [3:0]        byte_en;

   assign idx        = cur_addr[ADDR_W+1:2];
   assign misaligned = (cur_addr[1:0] != 2'b00);

   generate
      if (ADDR_W < 30) begin : g_range
         assign out_of_range = |cur_addr[31:ADDR_W+2];
      end else begin : g_full
         assign out_of_range = 1'b0;
      end
   endgenerate

   assign is_read    =  cur_oe & ~cur_we;
   assign is_write   =  cur_we & ~cur_oe;
   assign is_illegal =  cur_we &  cur_oe;
   assign resp_err   = is_illegal | ((is_read | is_write) & (misaligned | out_of_range));

   assign enter_resp = ((state == S_WAIT) && (wait_cnt == 4'd0)) ||
                       ((state == S_IDLE) && bus.ram_cs && (WAIT_CYCLES == 0));
   assign do_write   = enter_resp & is_write & ~misaligned & ~out_of_range;

`ifdef MEM_BYTE_WRITE_EN
   assign byte_en = cur_wstrb;
`else
   logic unused_wstrb;
   assign unused_wstrb = ^cur_wstrb;
   assign byte_en      = 4'hF;
`endif

   // NOTE: the array has no reset; keeping it out of the reset block lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         wait_cnt  <= 4'd0;
         req_we    <= 1'b0;
         req_oe    <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         req_wstrb <= '0;
         bus.ready <= 1'b0;
         bus.err   <= 1'b0;
         bus.rdata <= '0;
      end else begin
         bus.ready <= enter_resp;
         bus.err   <= enter_resp & resp_err;
         // Misaligned reads leave rdata alone; out-of-range reads return zero.
         if (enter_resp && is_read && !misaligned) begin
            bus.rdata <= out_of_range ? '0 : mem[idx];
         end

         case (state)
            S_IDLE: begin
               if (bus.ram_cs) begin
                  req_we    <= bus.ram_we;
                  req_oe    <= bus.ram_oe;
                  req_addr  <= bus.addr;
                  req_wdata <= bus.wdata;
                  req_wstrb <= bus.wstrb;
                  if (WAIT_CYCLES == 0) begin
                     state <= S_RESP;
                  end else begin
                     state    <= S_WAIT;
                     wait_cnt <= CNT_LOAD;
                  end
               end
            end
            S_WAIT: begin
               if (wait_cnt == 4'd0) state <= S_RESP;
               else                  wait_cnt <= wait_cnt - 4'd1;
            end
            S_RESP:  state <= bus.ram_cs ? S_HOLD : S_IDLE;
            S_HOLD:  if (!bus.ram_cs) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (1 and 3 wait states) checked through a
// queue of expected responses filled at request time and drained when ready pulses.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst_a;
   logic        rst_b;
   logic        cs_a;
   logic        cs_b;
   logic        we;
   logic        oe;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;

   always #5 clk = ~clk;

   mem_responder_if bus_a ();
   mem_responder_if bus_b ();

   assign bus_a.ram_cs = cs_a;
   assign bus_a.ram_we = we;
   assign bus_a.ram_oe = oe;
   assign bus_a.addr   = addr;
   assign bus_a.wdata  = wdata;
   assign bus_a.wstrb  = wstrb;
   assign bus_b.ram_cs = cs_b;
   assign bus_b.ram_we = we;
   assign bus_b.ram_oe = oe;
   assign bus_b.addr   = addr;
   assign bus_b.wdata  = wdata;
   assign bus_b.wstrb  = wstrb;

   mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(1)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a.slave)
   );

   mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(3)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b.slave)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic get_ready(input bit sel);
      return sel ? bus_b.ready : bus_a.ready;
   endfunction

   function automatic logic get_err(input bit sel);
      return sel ? bus_b.err : bus_a.err;
   endfunction

   function automatic logic [31:0] get_rdata(input bit sel);
      return sel ? bus_b.rdata : bus_a.rdata;
   endfunction

   // One complete transaction: single-cycle chip select, then wait (bounded) for ready.
   task automatic do_req(input bit sel, input bit w, input bit o, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] exp_rd, input bit exp_err, input string tag);
      exp_t e;
      int   n;
      bit   seen;
      int   lat;
      lat = sel ? 3 : 1;
      sb.push_back('{tag, exp_rd, exp_err});
      @(posedge clk); #1;
      we = w; oe = o; addr = a; wdata = d; wstrb = s;
      if (sel) cs_b = 1'b1; else cs_a = 1'b1;
      @(posedge clk); #1;
      cs_a = 1'b0; cs_b = 1'b0; we = 1'b0; oe = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         if (get_ready(sel) === 1'b1) seen = 1'b1;
         else n++;
      end
      e = sb.pop_front();
      check({e.tag, " latency"}, 32'(n), 32'(lat));
      if (seen) begin
         check({e.tag, " rdata"}, get_rdata(sel), e.rdata);
         check({e.tag, " err"}, 32'(get_err(sel)), 32'(e.err));
         @(negedge clk);
         check({e.tag, " ready pulse width"}, 32'(get_ready(sel)), 32'd0);
         check({e.tag, " err without ready"}, 32'(get_err(sel)), 32'd0);
      end
   endtask

   initial begin
      int          pulses;
      logic [31:0] exp_bw;
      logic [31:0] exp_zs;

`ifdef MEM_BYTE_WRITE_EN
      exp_bw = 32'h11BB11DD;
      exp_zs = 32'h22222222;
`else
      exp_bw = 32'hAABBCCDD;
      exp_zs = 32'h12345678;
`endif

      rst_a = 1'b1; rst_b = 1'b1;
      cs_a = 1'b0; cs_b = 1'b0; we = 1'b0; oe = 1'b0;
      addr = '0; wdata = '0; wstrb = '0;
      repeat (2) @(posedge clk);
      #1 rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      check("reset a ready", 32'(bus_a.ready), 32'd0);
      check("reset a err",   32'(bus_a.err),   32'd0);
      check("reset a rdata", bus_a.rdata,      32'd0);
      check("reset b rdata", bus_b.rdata,      32'd0);

      // Basic write / read with one wait state
      do_req(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,      0, "wr 0x10");
      do_req(0, 0, 1, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 0, "rd 0x10");

      // Chip select held for six cycles: exactly one response
      sb.push_back('{"hold rd 0x10", 32'hDEADBEEF, 1'b0});
      @(posedge clk); #1;
      we = 1'b0; oe = 1'b1; addr = 32'h10; cs_a = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus_a.ready === 1'b1) begin
            exp_t e;
            pulses++;
            e = sb.pop_front();
            check({e.tag, " rdata"}, bus_a.rdata, e.rdata);
            check({e.tag, " err"}, 32'(bus_a.err), 32'(e.err));
         end
      end
      cs_a = 1'b0; oe = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus_a.ready === 1'b1) pulses++;
      end
      check("hold pulse count", 32'(pulses), 32'd1);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.tag, " missing response"}, 32'd0, 32'd1);
      end
      do_req(0, 0, 1, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, "rd after hold");

      // Address faults
      do_req(0, 0, 1, 32'h12,   32'h0, 4'h0, 32'hDEADBEEF, 1, "rd misaligned");
      do_req(0, 0, 1, 32'h1000, 32'h0, 4'h0, 32'h0,        1, "rd out of range");

      // Illegal we+oe must not write
      do_req(0, 1, 0, 32'h20, 32'h0,        4'hF, 32'h0,        0, "wr 0x20 zero");
      do_req(0, 0, 1, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 0, "rd 0x10 prime");
      do_req(0, 1, 1, 32'h20, 32'h12345678, 4'hF, 32'hDEADBEEF, 1, "illegal 0x20");
      do_req(0, 0, 1, 32'h20, 32'h0,        4'h0, 32'h0,        0, "rd 0x20");

      // No-op, then faulted writes that must not land on word 0x10
      do_req(0, 0, 0, 32'h10,   32'h0,        4'h0, 32'h0,        0, "noop");
      do_req(0, 1, 0, 32'h12,   32'hCAFEF00D, 4'hF, 32'h0,        1, "wr misaligned");
      do_req(0, 1, 0, 32'h1010, 32'hCAFEF00D, 4'hF, 32'h0,        1, "wr out of range");
      do_req(0, 0, 1, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 0, "rd 0x10 intact");

      // Byte strobes
      do_req(0, 1, 0, 32'h40, 32'h11111111, 4'hF, 32'hDEADBEEF, 0, "wr 0x40 base");
      do_req(0, 1, 0, 32'h40, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 0, "wr 0x40 strobed");
      do_req(0, 0, 1, 32'h40, 32'h0,        4'h0, exp_bw,       0, "rd 0x40");
      do_req(0, 1, 0, 32'h44, 32'h22222222, 4'hF, exp_bw,       0, "wr 0x44 base");
      do_req(0, 1, 0, 32'h44, 32'h12345678, 4'h0, exp_bw,       0, "wr 0x44 zero strobe");
      do_req(0, 0, 1, 32'h44, 32'h0,        4'h0, exp_zs,       0, "rd 0x44");

      // Three wait states, then reset in the middle of a write
      do_req(1, 1, 0, 32'h30, 32'h00000077, 4'hF, 32'h0,  0, "b wr 0x30");
      do_req(1, 0, 1, 32'h30, 32'h0,        4'h0, 32'h77, 0, "b rd 0x30");
      @(posedge clk); #1;
      we = 1'b1; oe = 1'b0; addr = 32'h30; wdata = 32'h00000099; wstrb = 4'hF; cs_b = 1'b1;
      @(posedge clk); #1;
      cs_b = 1'b0; we = 1'b0;
      @(posedge clk); #3;
      rst_b = 1'b1;
      #1;
      check("b reset ready", 32'(bus_b.ready), 32'd0);
      check("b reset err",   32'(bus_b.err),   32'd0);
      check("b reset rdata", bus_b.rdata,      32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_b = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus_b.ready === 1'b1) pulses++;
      end
      check("b aborted pulses", 32'(pulses), 32'd0);
      do_req(1, 0, 1, 32'h30, 32'h0, 4'h0, 32'h77, 0, "b rd 0x30 retained");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
